// File: rtl/regfile_wb_queue.sv
// -----------------------------------------------------------------------------
// regfile_wb_queue
//
// Write-side front end for the 3-read/1-write register file. Two writeback
// producers share the file's single write port:
//   - primary (ALU) writes, which are never stalled and always win the port;
//   - secondary (load, mul/div) writes, taken with a valid/ready handshake and
//     buffered in a small FIFO until the port is free.
// A primary write to R is program-newer than anything queued, so queued (and
// same-cycle) secondary writes to R are killed. A killed slot is still popped,
// but it produces no write.
// Per-read-index pending flags let decode stall on a register whose newest
// value has not yet reached the file.
//
// Optional feature (macro WB_BYPASS_EN): when the FIFO is empty and no primary
// write is present, an accepted secondary write goes straight to the output
// register instead of being enqueued.
//
// Parameters:
//   DEPTH      secondary FIFO entries (power of two, >= 2)
//   PTR_W      log2(DEPTH)
//
// Ports:
//   CLK                  clock, rising edge
//   RESET                asynchronous, active-low reset
//   PriValid/Reg/Data    primary writeback (present this cycle)
//   SecValid/Reg/Data    secondary writeback offer
//   SecReady             secondary writeback can be accepted (Count != DEPTH)
//   RegA/B/C             decode read indices
//   PendA/B/C            indexed register has an uncommitted write
//   WbWrite/Reg/Data     registered register-file write port
//   Count                FIFO occupancy, killed entries included
// -----------------------------------------------------------------------------
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             PriValid,
  input  logic [4:0]       PriReg,
  input  logic [31:0]      PriData,
  input  logic             SecValid,
  output logic             SecReady,
  input  logic [4:0]       SecReg,
  input  logic [31:0]      SecData,
  input  logic [4:0]       RegA,
  input  logic [4:0]       RegB,
  input  logic [4:0]       RegC,
  output logic             PendA,
  output logic             PendB,
  output logic             PendC,
  output logic             WbWrite,
  output logic [4:0]       WbReg,
  output logic [31:0]      WbData,
  output logic [PTR_W:0]   Count
);

  localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

  // FIFO storage. A valid bit of 1 implies the slot is occupied: valid is
  // cleared on pop and on kill, so pending lookups need no occupancy mask.
  logic [DEPTH-1:0] entryValid;
  logic [4:0]       entryReg  [DEPTH];
  logic [31:0]      entryData [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // Per-edge decisions.
  logic priTake;
  logic secAccept;
  logic bypass;
  logic push;
  logic pushValid;
  logic pop;

  assign SecReady  = (Count != FullCount);
  assign priTake   = PriValid && (PriReg != 5'd0);
  assign secAccept = SecValid && SecReady;

`ifdef WB_BYPASS_EN
  assign bypass = secAccept && (SecReg != 5'd0) && !priTake && (Count == '0);
`else
  assign bypass = 1'b0;
`endif

  // Register-0 secondary writes complete the handshake but are dropped here.
  assign push      = secAccept && (SecReg != 5'd0) && !bypass;
  // A same-cycle primary write to the same register is newer: enqueue killed.
  assign pushValid = !(priTake && (PriReg == SecReg));
  assign pop       = !priTake && (Count != '0);

  // NOTE: only the control state (valid bits, pointers, count, outputs) is
  // reset; the reg/data payload is qualified by valid, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      entryReg[tail]  <= SecReg;
      entryData[tail] <= SecData;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so several
  // updates to one valid bit in this block resolve as "last assignment wins"
  // without creating ordering races with other processes.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      entryValid <= '0;
      head       <= '0;
      tail       <= '0;
      Count      <= '0;
      WbWrite    <= 1'b0;
      WbReg      <= 5'd0;
      WbData     <= 32'd0;
    end else begin
      // Kill stored entries overtaken by the primary write.
      if (priTake) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (entryReg[i] == PriReg) entryValid[i] <= 1'b0;
        end
      end
      if (pop)  entryValid[head] <= 1'b0;
      // When full no push happens; otherwise tail never aliases a stored
      // entry, so this cannot clobber a kill or pop above.
      if (push) entryValid[tail] <= pushValid;

      if (pop)  head <= head + 1'b1;
      if (push) tail <= tail + 1'b1;

      case ({push, pop})
        2'b10:   Count <= Count + 1'b1;
        2'b01:   Count <= Count - 1'b1;
        default: Count <= Count;
      endcase

      // Output write port; WbReg/WbData hold when nothing is committed.
      if (priTake) begin
        WbWrite <= 1'b1;
        WbReg   <= PriReg;
        WbData  <= PriData;
      end else if (pop) begin
        WbWrite <= entryValid[head];
        if (entryValid[head]) begin
          WbReg  <= entryReg[head];
          WbData <= entryData[head];
        end
      end else if (bypass) begin
        WbWrite <= 1'b1;
        WbReg   <= SecReg;
        WbData  <= SecData;
      end else begin
        WbWrite <= 1'b0;
      end
    end
  end

  // Pending flags. The output register counts as pending because the file
  // only takes the write at the next edge, so its read port is stale now.
  // NOTE: every output gets a default at the top of the block so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    PendA = 1'b0;
    PendB = 1'b0;
    PendC = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid[i] && (entryReg[i] == RegA)) PendA = 1'b1;
      if (entryValid[i] && (entryReg[i] == RegB)) PendB = 1'b1;
      if (entryValid[i] && (entryReg[i] == RegC)) PendC = 1'b1;
    end
    if (WbWrite && (WbReg == RegA)) PendA = 1'b1;
    if (WbWrite && (WbReg == RegB)) PendB = 1'b1;
    if (WbWrite && (WbReg == RegC)) PendC = 1'b1;
    if (RegA == 5'd0) PendA = 1'b0;
    if (RegB == 5'd0) PendB = 1'b0;
    if (RegC == 5'd0) PendC = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_queue
//
// Directed bench for regfile_wb_queue (DEPTH=4). Inputs change 1 time unit
// after a rising edge; outputs are compared in the same settled window.
// Builds with or without WB_BYPASS_EN; the bypass step expects the matching
// latency.
// -----------------------------------------------------------------------------
module tb_regfile_wb_queue;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        PriValid;
  logic [4:0]  PriReg;
  logic [31:0] PriData;
  logic        SecValid;
  logic        SecReady;
  logic [4:0]  SecReg;
  logic [31:0] SecData;
  logic [4:0]  RegA, RegB, RegC;
  logic        PendA, PendB, PendC;
  logic        WbWrite;
  logic [4:0]  WbReg;
  logic [31:0] WbData;
  logic [2:0]  Count;

  int checks = 0;
  int errors = 0;

  regfile_wb_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .CLK(CLK), .RESET(RESET),
    .PriValid(PriValid), .PriReg(PriReg), .PriData(PriData),
    .SecValid(SecValid), .SecReady(SecReady), .SecReg(SecReg), .SecData(SecData),
    .RegA(RegA), .RegB(RegB), .RegC(RegC),
    .PendA(PendA), .PendB(PendB), .PendC(PendC),
    .WbWrite(WbWrite), .WbReg(WbReg), .WbData(WbData), .Count(Count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b0;
    PriValid = 1'b0; PriReg = 5'd0; PriData = 32'd0;
    SecValid = 1'b0; SecReg = 5'd0; SecData = 32'd0;
    RegA = 5'd5; RegB = 5'd3; RegC = 5'd8;

    // Reset then idle.
    step();
    step();
    check("rst_secready", SecReady, 1);
    check("rst_penda", PendA, 0);
    RESET = 1'b1;
    step();
    check("idle_wbwrite", WbWrite, 0);
    check("idle_count", Count, 0);
    check("idle_secready", SecReady, 1);
    check("idle_penda", PendA, 0);
    check("idle_pendb", PendB, 0);
    check("idle_pendc", PendC, 0);

    // Primary only.
    PriValid = 1'b1; PriReg = 5'd5; PriData = 32'hDEADBEEF;
    step();
    check("pri_wbwrite", WbWrite, 1);
    check("pri_wbreg", WbReg, 5);
    check("pri_wbdata", WbData, 32'hDEADBEEF);
    check("pri_penda", PendA, 1);
    PriValid = 1'b0;
    step();
    check("pri_wbwrite_off", WbWrite, 0);
    check("pri_penda_off", PendA, 0);

    // Fill the FIFO with regs 2..5 while the primary holds the port on reg 1.
    PriValid = 1'b1; PriReg = 5'd1; PriData = 32'h100;
    SecValid = 1'b1;
    SecReg = 5'd2; SecData = 32'h2; step(); check("fill_count1", Count, 1);
    SecReg = 5'd3; SecData = 32'h3; step(); check("fill_count2", Count, 2);
    check("fill_pendb_queued", PendB, 1);
    SecReg = 5'd4; SecData = 32'h4; step(); check("fill_count3", Count, 3);
    SecReg = 5'd5; SecData = 32'h5; step(); check("fill_count4", Count, 4);
    check("fill_secready_full", SecReady, 0);
    check("fill_wbreg_pri", WbReg, 1);
    // Offer reg 6 while full: refused now and on the release edge (pop, no push-through).
    SecReg = 5'd6; SecData = 32'h6; step();
    check("full_refuse_count", Count, 4);
    PriValid = 1'b0;
    step();
    check("drain2_wbwrite", WbWrite, 1);
    check("drain2_wbreg", WbReg, 2);
    check("drain2_wbdata", WbData, 32'h2);
    check("drain2_count_no_pushthrough", Count, 3);
    SecValid = 1'b0;
    step();
    check("drain3_wbreg", WbReg, 3);
    check("drain3_wbdata", WbData, 32'h3);
    check("drain3_wbwrite", WbWrite, 1);
    step();
    check("drain4_wbreg", WbReg, 4);
    check("drain4_wbdata", WbData, 32'h4);
    step();
    check("drain5_wbreg", WbReg, 5);
    check("drain5_wbdata", WbData, 32'h5);
    check("drain5_count", Count, 0);
    step();
    check("drained_wbwrite", WbWrite, 0);
    check("drained_wbreg_hold", WbReg, 5);

    // Kill a queued entry.
    RegA = 5'd7;
    PriValid = 1'b1; PriReg = 5'd1; PriData = 32'h100;
    SecValid = 1'b1; SecReg = 5'd7; SecData = 32'h11;
    step();
    check("kill_queued_count", Count, 1);
    check("kill_queued_penda", PendA, 1);
    SecValid = 1'b0; PriReg = 5'd7; PriData = 32'h22;
    step();
    check("kill_pri_wbreg", WbReg, 7);
    check("kill_pri_wbdata", WbData, 32'h22);
    check("kill_pri_count", Count, 1);
    check("kill_pri_penda", PendA, 1);
    PriValid = 1'b0;
    step();
    check("kill_pop_wbwrite", WbWrite, 0);
    check("kill_pop_count", Count, 0);
    check("kill_pop_penda", PendA, 0);
    check("kill_pop_wbdata_hold", WbData, 32'h22);

    // Same-cycle kill: secondary to reg 8 alongside primary to reg 8.
    PriValid = 1'b1; PriReg = 5'd8; PriData = 32'h80;
    SecValid = 1'b1; SecReg = 5'd8; SecData = 32'h88;
    step();
    check("samekill_wbdata", WbData, 32'h80);
    check("samekill_count", Count, 1);
    check("samekill_pendc", PendC, 1);
    PriValid = 1'b0; SecValid = 1'b0;
    step();
    check("samekill_pop_wbwrite", WbWrite, 0);
    check("samekill_pop_count", Count, 0);
    check("samekill_pop_pendc", PendC, 0);
    check("samekill_pop_wbdata_hold", WbData, 32'h80);

    // Register 0 from both sources.
    PriValid = 1'b1; PriReg = 5'd0; PriData = 32'hAA;
    SecValid = 1'b1; SecReg = 5'd0; SecData = 32'hBB;
    #1;
    check("reg0_secready", SecReady, 1);
    step();
    check("reg0_wbwrite", WbWrite, 0);
    check("reg0_count", Count, 0);
    PriValid = 1'b0; SecValid = 1'b0;
    step();
    check("reg0_wbwrite_after", WbWrite, 0);

    // Reset mid-queue.
    PriValid = 1'b1; PriReg = 5'd1; PriData = 32'h100;
    SecValid = 1'b1;
    SecReg = 5'd10; SecData = 32'hA; step();
    SecReg = 5'd11; SecData = 32'hB; step();
    SecReg = 5'd12; SecData = 32'hC; step();
    check("midrst_count_before", Count, 3);
    PriValid = 1'b0; SecValid = 1'b0;
    RESET = 1'b0;
    #1;
    check("midrst_count_async", Count, 0);
    check("midrst_wbwrite_async", WbWrite, 0);
    step();
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst_no_commit", WbWrite, 0);
      check("midrst_count_after", Count, 0);
    end

    // Secondary into an empty FIFO: bypass latency depends on the build.
    RegA = 5'd9;
    SecValid = 1'b1; SecReg = 5'd9; SecData = 32'h99;
    step();
    SecValid = 1'b0;
`ifdef WB_BYPASS_EN
    check("byp_wbwrite", WbWrite, 1);
    check("byp_wbreg", WbReg, 9);
    check("byp_wbdata", WbData, 32'h99);
    check("byp_count", Count, 0);
    check("byp_penda", PendA, 1);
    step();
    check("byp_wbwrite_off", WbWrite, 0);
`else
    check("nobyp_wbwrite_first", WbWrite, 0);
    check("nobyp_count", Count, 1);
    check("nobyp_penda_queued", PendA, 1);
    step();
    check("nobyp_wbwrite", WbWrite, 1);
    check("nobyp_wbreg", WbReg, 9);
    check("nobyp_wbdata", WbData, 32'h99);
    check("nobyp_count_after", Count, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
